// File: rtl/debounce_sync_pkg.sv
// Shared types and default sizing for the debounce/synchronizer block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_sync_if.sv
// Level-signal bundle between a raw pin source and the debouncer.
// No valid/ready handshake: d_in is a free-running level and every output is a registered level.
interface debounce_sync_if #(parameter int GLITCH_W = 8);
  import debounce_pkg::*;

  logic                d_in;
  logic                d_out;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;
  db_state_e           state;

  modport master (output d_in, input d_out, input busy, input glitch_cnt, input state);
  modport slave  (input d_in, output d_out, output busy, output glitch_cnt, output state);
endinterface

// File: rtl/debounce_sync_sync_chain.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw pin and accepts a new level only after DEBOUNCE_CYCLES stable samples;
// rejected candidates are counted in a saturating glitch counter.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = 8
) (
  input logic            clk,
  input logic            rst,
  debounce_sync_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic                s;
  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                d_out_q, d_out_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                cnt_done;
  logic [GLITCH_W-1:0] glitch_inc;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.d_in),
    .q   (s)
  );

  assign cnt_done   = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign glitch_inc = (glitch_q == '1) ? glitch_q : glitch_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      d_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d_out_q  <= d_out_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_LOW:  if (s) state_d = WAIT_HIGH;
      WAIT_HIGH: if (!s) state_d = IDLE_LOW;  else if (cnt_done) state_d = IDLE_HIGH;
      IDLE_HIGH: if (!s) state_d = WAIT_LOW;
      WAIT_LOW:  if (s) state_d = IDLE_HIGH;  else if (cnt_done) state_d = IDLE_LOW;
      default:   state_d = IDLE_LOW;
    endcase
  end

  // cnt counts samples already seen at the candidate level; it returns to 0 whenever idle.
  always_comb begin
    cnt_d    = '0;
    d_out_d  = d_out_q;
    glitch_d = glitch_q;
    busy_d   = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    case (state_q)
      IDLE_LOW:  if (s) cnt_d = CNT_W'(1);
      IDLE_HIGH: if (!s) cnt_d = CNT_W'(1);
      WAIT_HIGH: begin
        if (!s)            glitch_d = glitch_inc;
        else if (cnt_done) d_out_d  = 1'b1;
        else               cnt_d    = cnt_q + 1'b1;
      end
      WAIT_LOW: begin
        if (s)             glitch_d = glitch_inc;
        else if (cnt_done) d_out_d  = 1'b0;
        else               cnt_d    = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.d_out      = d_out_q;
  assign bus.busy       = busy_q;
  assign bus.glitch_cnt = glitch_q;
  assign bus.state      = state_q;

endmodule
